sfp_topk: RTL and testbench
===========================

# sfp_topk

Post-processing stage between the psum SRAM read port and the result interface. It accumulates per-lane partial distances over multiple tiles. At the end of each candidate group it inserts the `col` accumulated distances, one per cycle, into a descending sorted list of the K furthest candidates, with their indices. The list can be read back through a registered read port.

## Interface
- `psum_bw`, 16, width of one psum lane in SRAM1 words
- `col`, 8, lanes per word (candidates per group)
- `acc_bw`, 20, accumulator/distance width (>= psum_bw)
- `K`, 4, list depth (1..col*64)
- `idx_bw`, 11, candidate index width
- `clk`  in  1  rising-edge clock; one clock; reset is synchronous and active-high
- `reset`  in  1  synchronous active-high reset
- `acc_in`  in  1  psum_in valid; accumulate this word
- `last_in`  in  1  qualifies acc_in; final tile of current group
- `psum_in`  in  psum_bw*col  lane j at bits [psum_bw*(j+1)-1 : psum_bw*j], unsigned
- `base_idx`  in  idx_bw  index of lane 0; sampled when acc_in&last_in
- `clear`  in  1  empty list and accumulators (new query)
- `ready`  out  1  block accepts acc_in this cycle
- `count`  out  clog2(K+1)  valid list entries
- `rd_en`  in  1  read request
- `rd_addr`  in  clog2(K)  entry 0 = largest
- `rd_valid`  out  1  rd_dist/rd_idx valid
- `rd_dist`  out  acc_bw  distance of entry
- `rd_idx`  out  idx_bw  candidate index of entry

## Operation
- States: ACCUM (ready=1), INSERT (ready=0). Reset → ACCUM.
- ACCUM, acc_in=1: each lane acc[j] ← sat(acc[j] + zero-extended psum lane j). Saturate at 2^acc_bw−1; never wrap.
- acc_in & last_in: the post-add values go to an insert buffer. Each lane's index = (base_idx + j) mod 2^idx_bw. Accumulators → 0. State → INSERT, lane counter = 0.
- INSERT: one lane per cycle, lane 0 first.
  - List held sorted descending.
  - New entry goes below all entries with distance >= it (ties: earlier entry keeps rank).
  - List not full: always inserted, count+1.
  - List full: inserted only if dist > entry K−1; entry K−1 discarded.
  - After lane col−1: → ACCUM.
- acc_in while ready=0: ignored, no state change.
- clear: takes priority over everything.
  - Next cycle: count=0, accumulators=0, insert aborted, state ACCUM.
  - clear & acc_in in the same cycle: the data is dropped.
- Read: rd_addr >= count returns rd_dist=0, rd_idx=0 with rd_valid=1. Reads are allowed in any state; they return list contents as of the read cycle's edge.
- reset: all registers 0, state ACCUM, any in-flight group lost.

## Timing
- Reset values: ready=1, count=0, rd_valid=0, rd_dist=0, rd_idx=0.
- acc_in (non-last) at edge t: accumulator updated at t. Back-to-back acc_in every cycle is supported.
- last_in at edge t:
  - ready=0 during cycles t+1..t+col.
  - ready=1 at t+col+1.
  - Lane j is inserted at edge t+1+j; count updates at the same edge.
  - List final after edge t+col.
- Read latency 1: rd_en at edge t → rd_valid/rd_dist/rd_idx valid after edge t. rd_valid is 0 the cycle after rd_en=0.
- No combinational path from any input to any output; all outputs are registered.

## Test plan
- Reset → ready=1, count=0, rd_valid=0; read addr 0 → rd_valid=1, dist 0, idx 0.
- One group: lanes 10,50,20,80,30,70,60,40, last_in, base_idx=0.
  - ready low 8 cycles.
  - count=4.
  - Entries 0..3 = (80,3),(70,5),(60,6),(50,1).
- Ties: follow the above with a group of all lanes 80, base_idx=8 → entries (80,3),(80,8),(80,9),(80,10); count stays 4.
- Saturation: 16 tiles of all lanes 0xFFFF → lane sum 0xFFFF0. A 17th tile (last) → all distances 0xFFFFF; entries idx 0,1,2,3.
- clear at 3rd INSERT cycle → next cycle count=0, ready=1. A following group inserts from an empty list.
- acc_in with psum 0x0100 pulsed during INSERT → ignored; the next accumulated group sums exclude it.

Source files
------------

// File: rtl/sfp_topk.sv
// Top-K (furthest) selection stage: accumulates per-lane psums across tiles, then inserts each
// group's lane distances one per cycle into a descending sorted list with a registered read port.
module sfp_topk #(
    parameter int unsigned psum_bw = 16,
    parameter int unsigned col     = 8,
    parameter int unsigned acc_bw  = 20,
    parameter int unsigned K       = 4,
    parameter int unsigned idx_bw  = 11,
    localparam int unsigned CntW   = $clog2(K + 1),
    localparam int unsigned AddrW  = (K > 1) ? $clog2(K) : 1,
    localparam int unsigned LaneW  = (col > 1) ? $clog2(col) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     acc_in,
    input  logic                     last_in,
    input  logic [psum_bw*col-1:0]   psum_in,
    input  logic [idx_bw-1:0]        base_idx,
    input  logic                     clear,
    output logic                     ready,
    output logic [CntW-1:0]          count,
    input  logic                     rd_en,
    input  logic [AddrW-1:0]         rd_addr,
    output logic                     rd_valid,
    output logic [acc_bw-1:0]        rd_dist,
    output logic [idx_bw-1:0]        rd_idx
);

    typedef enum logic [0:0] {StAccum, StInsert} state_e;

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic [LaneW-1:0]    lane_q, lane_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [acc_bw-1:0]   acc_q [col];
    logic [acc_bw-1:0]   acc_d [col];
    logic [acc_bw-1:0]   buf_dist_q [col];
    logic [acc_bw-1:0]   buf_dist_d [col];
    logic [idx_bw-1:0]   buf_idx_q [col];
    logic [idx_bw-1:0]   buf_idx_d [col];
    logic [acc_bw-1:0]   list_dist_q [K];
    logic [acc_bw-1:0]   list_dist_d [K];
    logic [idx_bw-1:0]   list_idx_q [K];
    logic [idx_bw-1:0]   list_idx_d [K];
    logic                rd_valid_q, rd_valid_d;
    logic [acc_bw-1:0]   rd_dist_q, rd_dist_d;
    logic [idx_bw-1:0]   rd_idx_q, rd_idx_d;

    logic [acc_bw-1:0]   new_dist;
    logic [idx_bw-1:0]   new_idx;
    logic [acc_bw-1:0]   lane_sum;
    logic [K-1:0]        ge;

    function automatic logic [acc_bw-1:0] sat_add(input logic [acc_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
        logic [acc_bw:0] s;
        s = {1'b0, a} + {{(acc_bw + 1 - psum_bw){1'b0}}, b};
        return s[acc_bw] ? {acc_bw{1'b1}} : s[acc_bw-1:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        count_d     = count_q;
        acc_d       = acc_q;
        buf_dist_d  = buf_dist_q;
        buf_idx_d   = buf_idx_q;
        list_dist_d = list_dist_q;
        list_idx_d  = list_idx_q;
        rd_valid_d  = rd_en;
        rd_dist_d   = rd_dist_q;
        rd_idx_d    = rd_idx_q;
        lane_sum    = '0;
        new_dist    = buf_dist_q[lane_q];
        new_idx     = buf_idx_q[lane_q];

        // ge is a prefix mask: valid entries that keep their rank above the new one
        ge = '0;
        for (int k = 0; k < K; k++) begin
            ge[k] = (CntW'(k) < count_q) && (list_dist_q[k] >= new_dist);
        end

        unique case (state_q)
            StAccum: begin
                if (acc_in) begin
                    for (int j = 0; j < col; j++) begin
                        lane_sum = sat_add(acc_q[j], psum_in[psum_bw*j +: psum_bw]);
                        if (last_in) begin
                            buf_dist_d[j] = lane_sum;
                            buf_idx_d[j]  = base_idx + idx_bw'(j);
                            acc_d[j]      = '0;
                        end else begin
                            acc_d[j] = lane_sum;
                        end
                    end
                    if (last_in) begin
                        state_d = StInsert;
                        lane_d  = '0;
                    end
                end
            end
            StInsert: begin
                // Not full: ge[K-1] is 0. Full: insert only if strictly above the tail.
                if (!ge[K-1]) begin
                    if (!ge[0]) begin
                        list_dist_d[0] = new_dist;
                        list_idx_d[0]  = new_idx;
                    end
                    for (int k = 1; k < K; k++) begin
                        if (!ge[k]) begin
                            list_dist_d[k] = ge[k-1] ? new_dist : list_dist_q[k-1];
                            list_idx_d[k]  = ge[k-1] ? new_idx  : list_idx_q[k-1];
                        end
                    end
                    if (count_q < CntW'(K)) begin
                        count_d = count_q + CntW'(1);
                    end
                end
                if (lane_q == LaneW'(col - 1)) begin
                    state_d = StAccum;
                end else begin
                    lane_d = lane_q + LaneW'(1);
                end
            end
            default: state_d = StAccum;
        endcase

        if (rd_en) begin
            if (int'(rd_addr) < int'(count_q)) begin
                rd_dist_d = list_dist_q[rd_addr];
                rd_idx_d  = list_idx_q[rd_addr];
            end else begin
                rd_dist_d = '0;
                rd_idx_d  = '0;
            end
        end

        if (clear) begin
            state_d = StAccum;
            lane_d  = '0;
            count_d = '0;
            for (int j = 0; j < col; j++) begin
                acc_d[j] = '0;
            end
        end

        ready_d = (state_d == StAccum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StAccum;
            ready_q     <= 1'b1;
            lane_q      <= '0;
            count_q     <= '0;
            acc_q       <= '{default: '0};
            buf_dist_q  <= '{default: '0};
            buf_idx_q   <= '{default: '0};
            list_dist_q <= '{default: '0};
            list_idx_q  <= '{default: '0};
            rd_valid_q  <= 1'b0;
            rd_dist_q   <= '0;
            rd_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            lane_q      <= lane_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            buf_dist_q  <= buf_dist_d;
            buf_idx_q   <= buf_idx_d;
            list_dist_q <= list_dist_d;
            list_idx_q  <= list_idx_d;
            rd_valid_q  <= rd_valid_d;
            rd_dist_q   <= rd_dist_d;
            rd_idx_q    <= rd_idx_d;
        end
    end

    assign ready    = ready_q;
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign rd_dist  = rd_dist_q;
    assign rd_idx   = rd_idx_q;

endmodule

// File: tb/tb_sfp_topk.sv
// Bench for sfp_topk: queue-based top-K model checked every cycle, plus directed groups with
// literal expectations for ordering, ties, saturation, index wrap, clear and ignored input.
module tb_sfp_topk;

    localparam int unsigned PB = 16;
    localparam int unsigned NC = 8;
    localparam int unsigned AB = 20;
    localparam int unsigned KK = 4;
    localparam int unsigned IB = 11;
    localparam int unsigned SatMax = (1 << AB) - 1;

    typedef struct {
        int unsigned d;
        int unsigned i;
    } ent_t;
    typedef int unsigned lanes_t [NC];

    logic             clk = 1'b0;
    logic             reset;
    logic             acc_in;
    logic             last_in;
    logic [PB*NC-1:0] psum_in;
    logic [IB-1:0]    base_idx;
    logic             clear;
    logic             ready;
    logic [2:0]       count;
    logic             rd_en;
    logic [1:0]       rd_addr;
    logic             rd_valid;
    logic [AB-1:0]    rd_dist;
    logic [IB-1:0]    rd_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    sfp_topk dut (
        .clk      (clk),
        .reset    (reset),
        .acc_in   (acc_in),
        .last_in  (last_in),
        .psum_in  (psum_in),
        .base_idx (base_idx),
        .clear    (clear),
        .ready    (ready),
        .count    (count),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_valid (rd_valid),
        .rd_dist  (rd_dist),
        .rd_idx   (rd_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: accumulators, a pending-insert queue and a sorted list.
    int unsigned m_acc [NC];
    ent_t        m_pend [$];
    ent_t        m_list [$];
    bit          m_live = 0;
    bit          m_rdv;
    int unsigned m_rdd, m_rdi;

    function automatic void model_insert(input ent_t e);
        int pos;
        pos = 0;
        while (pos < m_list.size() && m_list[pos].d >= e.d) pos++;
        if (pos < KK) begin
            m_list.insert(pos, e);
            if (m_list.size() > KK) void'(m_list.pop_back());
        end
    endfunction

    // Compare at negedge, then advance the model with the inputs the next posedge will sample.
    initial begin
        ent_t        e;
        int unsigned s;
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("ready", ready, (m_pend.size() == 0));
                check("count", count, m_list.size());
                check("rd_valid", rd_valid, m_rdv);
                if (m_rdv) begin
                    check("rd_dist", rd_dist, m_rdd);
                    check("rd_idx", rd_idx, m_rdi);
                end
            end
            if (reset) begin
                foreach (m_acc[j]) m_acc[j] = 0;
                m_pend.delete();
                m_list.delete();
                m_rdv = 0; m_rdd = 0; m_rdi = 0;
                m_live = 1;
            end else if (m_live) begin
                if (rd_en) begin
                    m_rdv = 1;
                    if (rd_addr < m_list.size()) begin
                        m_rdd = m_list[rd_addr].d;
                        m_rdi = m_list[rd_addr].i;
                    end else begin
                        m_rdd = 0; m_rdi = 0;
                    end
                end else begin
                    m_rdv = 0;
                end
                if (clear) begin
                    foreach (m_acc[j]) m_acc[j] = 0;
                    m_pend.delete();
                    m_list.delete();
                end else if (m_pend.size() != 0) begin
                    e = m_pend.pop_front();
                    model_insert(e);
                end else if (acc_in) begin
                    for (int j = 0; j < NC; j++) begin
                        s = m_acc[j] + int'(psum_in[PB*j +: PB]);
                        m_acc[j] = (s > SatMax) ? SatMax : s;
                        if (last_in) begin
                            e.d = m_acc[j];
                            e.i = (int'(base_idx) + j) % (1 << IB);
                            m_pend.push_back(e);
                            m_acc[j] = 0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [PB*NC-1:0] pack(input lanes_t v);
        logic [PB*NC-1:0] w;
        for (int j = 0; j < NC; j++) w[PB*j +: PB] = PB'(v[j]);
        return w;
    endfunction

    task automatic send_tile(input logic [PB*NC-1:0] w, input bit last, input int unsigned base);
        acc_in = 1'b1; last_in = last; psum_in = w; base_idx = IB'(base);
        @(posedge clk); #1;
        acc_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_entry(input int a, output logic [AB-1:0] d, output logic [IB-1:0] i,
                              output logic v);
        rd_en = 1'b1; rd_addr = 2'(a);
        @(posedge clk); #1;
        d = rd_dist; i = rd_idx; v = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic expect_list(input string tag, input lanes_t dists, input lanes_t idxs);
        logic [AB-1:0] d;
        logic [IB-1:0] i;
        logic          v;
        for (int a = 0; a < KK; a++) begin
            read_entry(a, d, i, v);
            check($sformatf("%s_dist%0d", tag, a), d, dists[a]);
            check($sformatf("%s_idx%0d", tag, a), i, idxs[a]);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        int            n;
        logic [AB-1:0] d;
        logic [IB-1:0] i;
        logic          v;
        reset = 1'b1; acc_in = 1'b0; last_in = 1'b0; psum_in = '0; base_idx = '0;
        clear = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_count", count, 0);
        check("rst_rd_valid", rd_valid, 0);
        read_entry(0, d, i, v);
        check("rst_read_valid", v, 1);
        check("rst_read_dist", d, 0);
        check("rst_read_idx", i, 0);

        // Basic group ordering
        send_tile(pack('{10, 50, 20, 80, 30, 70, 60, 40}), 1, 0);
        wait_ready(n);
        check("ready_low_cycles", n, 8);
        check("g1_count", count, 4);
        expect_list("g1", '{80, 70, 60, 50, 0, 0, 0, 0}, '{3, 5, 6, 1, 0, 0, 0, 0});

        // Ties: earlier entries keep rank
        send_tile(pack('{80, 80, 80, 80, 80, 80, 80, 80}), 1, 8);
        wait_ready(n);
        check("tie_ready", ready, 1);
        check("tie_count", count, 4);
        expect_list("tie", '{80, 80, 80, 80, 0, 0, 0, 0}, '{3, 8, 9, 10, 0, 0, 0, 0});

        // Saturation: 16 tiles reach 0xFFFF0, 17 tiles clamp to 0xFFFFF
        do_clear();
        for (int t = 0; t < 16; t++)
            send_tile(pack('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                             16'hFFFF, 16'hFFFF}), (t == 15), 0);
        wait_ready(n);
        check("sat16_ready", ready, 1);
        expect_list("sat16", '{20'hFFFF0, 20'hFFFF0, 20'hFFFF0, 20'hFFFF0, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0});
        for (int t = 0; t < 17; t++)
            send_tile(pack('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                             16'hFFFF, 16'hFFFF}), (t == 16), 0);
        wait_ready(n);
        check("sat17_ready", ready, 1);
        expect_list("sat17", '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 0, 0, 0, 0},
                    '{0, 1, 2, 3, 0, 0, 0, 0});

        // Index wraps modulo 2^idx_bw
        do_clear();
        send_tile(pack('{5, 5, 5, 5, 5, 5, 5, 5}), 1, 2046);
        wait_ready(n);
        expect_list("wrap", '{5, 5, 5, 5, 0, 0, 0, 0}, '{2046, 2047, 0, 1, 0, 0, 0, 0});

        // Clear during the third insert cycle aborts the group
        send_tile(pack('{90, 91, 92, 93, 94, 95, 96, 97}), 1, 40);
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_clear();
        check("clr_count", count, 0);
        check("clr_ready", ready, 1);
        read_entry(2, d, i, v);
        check("clr_read_dist", d, 0);
        send_tile(pack('{1, 2, 3, 4, 5, 6, 7, 8}), 1, 100);
        wait_ready(n);
        expect_list("post_clr", '{8, 7, 6, 5, 0, 0, 0, 0}, '{107, 106, 105, 104, 0, 0, 0, 0});

        // acc_in during INSERT must not leak into the next group
        do_clear();
        send_tile(pack('{1, 2, 3, 4, 5, 6, 7, 8}), 1, 0);
        send_tile(pack('{16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100, 16'h100,
                         16'h100}), 0, 0);
        wait_ready(n);
        send_tile(pack('{10, 10, 10, 10, 10, 10, 10, 10}), 1, 20);
        wait_ready(n);
        expect_list("ign", '{10, 10, 10, 10, 0, 0, 0, 0}, '{20, 21, 22, 23, 0, 0, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        check("idle_rd_valid", rd_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
